// File: rtl/sr_mc_pkg.sv
// Shared types and encodings for the multi-cycle schoolRISCV-style control unit:
// FSM states, instruction classes, ALU operation codes and RV32 field encodings.
package sr_mc_pkg;

  localparam logic [6:0] RVOP_ADDI = 7'b0010011;
  localparam logic [6:0] RVOP_BEQ  = 7'b1100011;
  localparam logic [6:0] RVOP_LUI  = 7'b0110111;
  localparam logic [6:0] RVOP_BNE  = 7'b1100011;
  localparam logic [6:0] RVOP_ADD  = 7'b0110011;
  localparam logic [6:0] RVOP_OR   = 7'b0110011;
  localparam logic [6:0] RVOP_SRL  = 7'b0110011;
  localparam logic [6:0] RVOP_SLTU = 7'b0110011;
  localparam logic [6:0] RVOP_SUB  = 7'b0110011;

  localparam logic [2:0] RVF3_ADDI = 3'b000;
  localparam logic [2:0] RVF3_BEQ  = 3'b000;
  localparam logic [2:0] RVF3_BNE  = 3'b001;
  localparam logic [2:0] RVF3_ADD  = 3'b000;
  localparam logic [2:0] RVF3_OR   = 3'b110;
  localparam logic [2:0] RVF3_SRL  = 3'b101;
  localparam logic [2:0] RVF3_SLTU = 3'b011;
  localparam logic [2:0] RVF3_SUB  = 3'b000;

  localparam logic [6:0] RVF7_ADD  = 7'b0000000;
  localparam logic [6:0] RVF7_OR   = 7'b0000000;
  localparam logic [6:0] RVF7_SRL  = 7'b0000000;
  localparam logic [6:0] RVF7_SLTU = 7'b0000000;
  localparam logic [6:0] RVF7_SUB  = 7'b0100000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SRL  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StWb,
    StTrap
  } sr_mc_state_e;

  typedef enum logic [3:0] {
    ClsIllegal,
    ClsAdd,
    ClsOr,
    ClsSrl,
    ClsSltu,
    ClsSub,
    ClsAddi,
    ClsLui,
    ClsBeq,
    ClsBne
  } sr_mc_cls_e;

  function automatic logic [2:0] cls_alu_op(input sr_mc_cls_e cls);
    logic [2:0] op;
    op = ALU_ADD;
    unique case (cls)
      ClsOr:          op = ALU_OR;
      ClsSrl:         op = ALU_SRL;
      ClsSltu:        op = ALU_SLTU;
      ClsSub:         op = ALU_SUB;
      ClsBeq, ClsBne: op = ALU_SUB;
      default:        op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic cls_is_branch(input sr_mc_cls_e cls);
    return (cls == ClsBeq) || (cls == ClsBne);
  endfunction

endpackage

// File: rtl/sr_mc_decode.sv
// Combinational instruction classifier: maps {F7, F3, opcode} to an instruction class.
module sr_mc_decode
  import sr_mc_pkg::*;
(
  input  logic [6:0]  cmd_op_i,
  input  logic [2:0]  cmd_f3_i,
  input  logic [6:0]  cmd_f7_i,
  output sr_mc_cls_e  cls_o
);

  always_comb begin
    cls_o = ClsIllegal;
    casez ({cmd_f7_i, cmd_f3_i, cmd_op_i})
      {RVF7_ADD,  RVF3_ADD,  RVOP_ADD }: cls_o = ClsAdd;
      {RVF7_OR,   RVF3_OR,   RVOP_OR  }: cls_o = ClsOr;
      {RVF7_SRL,  RVF3_SRL,  RVOP_SRL }: cls_o = ClsSrl;
      {RVF7_SLTU, RVF3_SLTU, RVOP_SLTU}: cls_o = ClsSltu;
      {RVF7_SUB,  RVF3_SUB,  RVOP_SUB }: cls_o = ClsSub;
      // I/U/B formats ignore the fields that carry immediate bits
      {7'b???????, RVF3_ADDI, RVOP_ADDI}: cls_o = ClsAddi;
      {7'b???????, 3'b???,    RVOP_LUI }: cls_o = ClsLui;
      {7'b???????, RVF3_BEQ,  RVOP_BEQ }: cls_o = ClsBeq;
      {7'b???????, RVF3_BNE,  RVOP_BNE }: cls_o = ClsBne;
      default:                            cls_o = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/sr_mc_control.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/WB/TRAP) with sticky illegal flag and a
// retired-instruction counter that advances on every PC update.
module sr_mc_control
  import sr_mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        imemReady,
  input  logic [6:0]  cmdOp,
  input  logic [2:0]  cmdF3,
  input  logic [6:0]  cmdF7,
  input  logic        aluZero,
  output logic        imemReq,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        pcSrc,
  output logic        regWrite,
  output logic        aluSrc,
  output logic        wdSrc,
  output logic [2:0]  aluControl,
  output logic        illegal,
  output logic [31:0] retired
);

  sr_mc_state_e state_q, state_d;
  sr_mc_cls_e   cls_q, cls_d, dec_cls;
  logic         illegal_q, illegal_d;
  logic [31:0]  retired_q, retired_d;

  sr_mc_decode u_decode (
    .cmd_op_i (cmdOp),
    .cmd_f3_i (cmdF3),
    .cmd_f7_i (cmdF7),
    .cls_o    (dec_cls)
  );

  // Outputs are forced to their idle values while reset is held, whatever the state.
  always_comb begin
    imemReq    = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 1'b0;
    regWrite   = 1'b0;
    aluSrc     = 1'b0;
    wdSrc      = 1'b0;
    aluControl = ALU_ADD;
    illegal    = illegal_q & rst_n;
    retired    = rst_n ? retired_q : '0;
    if (rst_n) begin
      unique case (state_q)
        StFetch: begin
          imemReq = enable;
          irWrite = enable & imemReady;
        end
        StExec, StWb: begin
          aluControl = cls_alu_op(cls_q);
          aluSrc     = (cls_q == ClsAddi);
          wdSrc      = (cls_q == ClsLui);
          if (state_q == StWb) begin
            regWrite = 1'b1;
            pcWrite  = 1'b1;
          end else if (cls_is_branch(cls_q)) begin
            pcWrite = 1'b1;
            pcSrc   = (aluZero == (cls_q == ClsBeq));
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    unique case (state_q)
      StFetch: begin
        if (enable && imemReady) state_d = StDecode;
      end
      StDecode: begin
        cls_d   = dec_cls;
        state_d = (dec_cls == ClsIllegal) ? StTrap : StExec;
      end
      StExec:  state_d = cls_is_branch(cls_q) ? StFetch : StWb;
      StWb:    state_d = StFetch;
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
    illegal_d = illegal_q | (state_d == StTrap);
    retired_d = pcWrite ? retired_q + 32'd1 : retired_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      cls_q     <= ClsIllegal;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_sr_mc_control.sv
// Directed bench for sr_mc_control: a per-instruction schedule model checked every cycle,
// plus literal spot checks at the cycles the requirements call out.
module tb_sr_mc_control;

  logic        clk = 1'b0;
  logic        rst_n, enable, imemReady, aluZero;
  logic [6:0]  cmdOp, cmdF7;
  logic [2:0]  cmdF3;
  logic        imemReq, irWrite, pcWrite, pcSrc, regWrite, aluSrc, wdSrc, illegal;
  logic [2:0]  aluControl;
  logic [31:0] retired;

  always #5 clk = ~clk;

  sr_mc_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .imemReady  (imemReady),
    .cmdOp      (cmdOp),
    .cmdF3      (cmdF3),
    .cmdF7      (cmdF7),
    .aluZero    (aluZero),
    .imemReq    (imemReq),
    .irWrite    (irWrite),
    .pcWrite    (pcWrite),
    .pcSrc      (pcSrc),
    .regWrite   (regWrite),
    .aluSrc     (aluSrc),
    .wdSrc      (wdSrc),
    .aluControl (aluControl),
    .illegal    (illegal),
    .retired    (retired)
  );

  // One entry per post-fetch cycle of the instruction in flight.
  typedef struct packed {
    logic [2:0] alu;
    logic asrc, wd, regw, pcw, br, cz, trap;
  } step_t;

  step_t       sched[$];
  bit          trapped;
  logic [31:0] m_ret;
  int          n_vec, n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic void plan(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    step_t s, ex, wb;
    bit ok = 1'b1, br = 1'b0, asrc = 1'b0, wd = 1'b0, cz = 1'b0;
    logic [2:0] alu = 3'd0;
    if      (op == 7'b0110011 && f7 == 7'b0000000 && f3 == 3'b000) alu = 3'd0;
    else if (op == 7'b0110011 && f7 == 7'b0000000 && f3 == 3'b110) alu = 3'd1;
    else if (op == 7'b0110011 && f7 == 7'b0000000 && f3 == 3'b101) alu = 3'd2;
    else if (op == 7'b0110011 && f7 == 7'b0000000 && f3 == 3'b011) alu = 3'd3;
    else if (op == 7'b0110011 && f7 == 7'b0100000 && f3 == 3'b000) alu = 3'd4;
    else if (op == 7'b0010011 && f3 == 3'b000) asrc = 1'b1;
    else if (op == 7'b0110111) wd = 1'b1;
    else if (op == 7'b1100011 && f3 == 3'b000) begin br = 1'b1; cz = 1'b1; alu = 3'd4; end
    else if (op == 7'b1100011 && f3 == 3'b001) begin br = 1'b1; cz = 1'b0; alu = 3'd4; end
    else ok = 1'b0;
    s = '0;
    s.trap = !ok;
    sched.push_back(s);
    if (!ok) return;
    ex = '0;
    ex.alu = alu; ex.asrc = asrc; ex.wd = wd;
    if (br) begin
      ex.pcw = 1'b1; ex.br = 1'b1; ex.cz = cz;
      sched.push_back(ex);
    end else begin
      sched.push_back(ex);
      wb = ex; wb.regw = 1'b1; wb.pcw = 1'b1;
      sched.push_back(wb);
    end
  endfunction

  task automatic model_check();
    logic e_req = 0, e_irw = 0, e_pcw = 0, e_pcs = 0, e_regw = 0, e_asrc = 0, e_wd = 0;
    logic e_ill = 0;
    logic [2:0] e_alu = 3'd0;
    logic [31:0] e_ret = 32'd0;
    step_t s;
    if (rst_n) begin
      e_ret = m_ret;
      e_ill = trapped;
      if (!trapped) begin
        if (sched.size() == 0) begin
          e_req = enable;
          e_irw = enable & imemReady;
        end else begin
          s = sched[0];
          e_alu = s.alu; e_asrc = s.asrc; e_wd = s.wd;
          e_regw = s.regw; e_pcw = s.pcw;
          e_pcs = s.br && (aluZero == s.cz);
        end
      end
    end
    check("m_imemReq", imemReq, e_req);
    check("m_irWrite", irWrite, e_irw);
    check("m_pcWrite", pcWrite, e_pcw);
    check("m_pcSrc", pcSrc, e_pcs);
    check("m_regWrite", regWrite, e_regw);
    check("m_aluSrc", aluSrc, e_asrc);
    check("m_wdSrc", wdSrc, e_wd);
    check("m_aluControl", aluControl, e_alu);
    check("m_illegal", illegal, e_ill);
    check("m_retired", retired, e_ret);
    if (!rst_n) begin
      sched.delete();
      trapped = 1'b0;
      m_ret = 32'd0;
    end else if (!trapped) begin
      if (sched.size() == 0) begin
        if (enable && imemReady) plan(cmdF7, cmdF3, cmdOp);
      end else begin
        s = sched.pop_front();
        if (s.pcw) m_ret++;
        if (s.trap) trapped = 1'b1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  task automatic set_ir(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    cmdF7 = f7; cmdF3 = f3; cmdOp = op;
  endtask

  // Fetch one instruction with ready high, then let it run for `post` more cycles.
  task automatic run(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op,
                     input logic z, input int post);
    set_ir(f7, f3, op);
    aluZero = z;
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    repeat (post) cyc();
  endtask

  logic [6:0] t_f7 [6] = '{7'h00, 7'h00, 7'h00, 7'h20, 7'h55, 7'h7f};
  logic [2:0] t_f3 [6] = '{3'b110, 3'b101, 3'b011, 3'b000, 3'b000, 3'b010};
  logic [6:0] t_op [6] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                           7'b0010011, 7'b0110111};

  initial begin
    n_vec = 0; n_bad = 0; trapped = 1'b0; m_ret = 32'd0;
    rst_n = 1'b0; enable = 1'b1; imemReady = 1'b1; aluZero = 1'b0;
    set_ir(7'h00, 3'b000, 7'b0110011);

    // Reset: outputs idle even with enable/ready high
    cyc();
    sample();
    check("rst_imemReq", imemReq, 1'b0);
    check("rst_aluControl", aluControl, 3'd0);
    check("rst_retired", retired, 32'd0);
    adv();
    rst_n = 1'b1;

    // ADD: fetch in cycle 0, regWrite+pcWrite in cycle 3
    set_ir(7'h00, 3'b000, 7'b0110011);
    sample();
    check("add_c0_imemReq", imemReq, 1'b1);
    check("add_c0_irWrite", irWrite, 1'b1);
    adv();
    enable = 1'b0;
    cyc(); cyc();
    sample();
    check("add_c3_regWrite", regWrite, 1'b1);
    check("add_c3_pcWrite", pcWrite, 1'b1);
    check("add_c3_pcSrc", pcSrc, 1'b0);
    adv();
    sample();
    check("add_retired", retired, 32'd1);
    adv();

    // BEQ taken with aluZero=1, branch strobes in cycle 2
    run(7'h00, 3'b000, 7'b1100011, 1'b1, 1);
    sample();
    check("beq_pcWrite", pcWrite, 1'b1);
    check("beq_pcSrc", pcSrc, 1'b1);
    check("beq_aluControl", aluControl, 3'd4);
    adv();
    // BNE not taken with aluZero=1
    run(7'h00, 3'b001, 7'b1100011, 1'b1, 1);
    sample();
    check("bne_pcWrite", pcWrite, 1'b1);
    check("bne_pcSrc", pcSrc, 1'b0);
    adv();
    run(7'h00, 3'b000, 7'b1100011, 1'b0, 2);
    run(7'h00, 3'b001, 7'b1100011, 1'b0, 2);
    sample();
    check("br4_retired", retired, 32'd5);
    adv();

    // ALU-class table: OR, SRL, SLTU, SUB, ADDI, LUI
    for (int i = 0; i < 6; i++) run(t_f7[i], t_f3[i], t_op[i], 1'b0, 4);

    // ADDI: aluSrc in EXEC
    set_ir(7'h12, 3'b000, 7'b0010011);
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    cyc();
    sample();
    check("addi_aluSrc", aluSrc, 1'b1);
    check("addi_aluControl", aluControl, 3'd0);
    adv();
    cyc();

    // Five wait cycles on imemReady
    set_ir(7'h00, 3'b110, 7'b0110011);
    enable = 1'b1;
    imemReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("wait_imemReq", imemReq, 1'b1);
      check("wait_irWrite", irWrite, 1'b0);
      adv();
    end
    imemReady = 1'b1;
    sample();
    check("wait6_irWrite", irWrite, 1'b1);
    adv();
    enable = 1'b0;
    repeat (3) cyc();
    // Dropping enable while waiting removes the request
    imemReady = 1'b0;
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    sample();
    check("drop_imemReq", imemReq, 1'b0);
    adv();
    imemReady = 1'b1;

    // Reset during EXEC of ADDI aborts it
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    set_ir(7'h00, 3'b000, 7'b0010011);
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    cyc();
    rst_n = 1'b0;
    sample();
    check("abort_regWrite", regWrite, 1'b0);
    adv();
    rst_n = 1'b1;
    enable = 1'b1;
    sample();
    check("abort_imemReq", imemReq, 1'b1);
    check("abort_regWrite2", regWrite, 1'b0);
    check("abort_retired", retired, 32'd0);
    adv();
    enable = 1'b0;
    repeat (3) cyc();

    // Counter wrap: preload all-ones, then LUI
    force dut.retired_d = 32'hFFFF_FFFF;
    sample();
    m_ret = 32'hFFFF_FFFF;
    adv();
    release dut.retired_d;
    sample();
    check("preload_retired", retired, 32'hFFFF_FFFF);
    adv();
    set_ir(7'h3c, 3'b101, 7'b0110111);
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    cyc();
    sample();
    check("lui_exec_wdSrc", wdSrc, 1'b1);
    adv();
    sample();
    check("lui_wb_wdSrc", wdSrc, 1'b1);
    check("lui_wb_regWrite", regWrite, 1'b1);
    adv();
    sample();
    check("lui_wrap_retired", retired, 32'd0);
    adv();

    // Illegal opcode traps in cycle 2 and holds with enable/ready high
    set_ir(7'h00, 3'b000, 7'b1111111);
    enable = 1'b1;
    cyc(); cyc();
    for (int i = 0; i < 20; i++) begin
      sample();
      check("trap_illegal", illegal, 1'b1);
      check("trap_imemReq", imemReq, 1'b0);
      check("trap_pcWrite", pcWrite, 1'b0);
      adv();
    end
    rst_n = 1'b0;
    set_ir(7'h00, 3'b000, 7'b0110011);
    cyc();
    rst_n = 1'b1;
    sample();
    check("post_trap_illegal", illegal, 1'b0);
    check("post_trap_imemReq", imemReq, 1'b1);
    adv();
    enable = 1'b0;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
